mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 167 ++++++++++++++++
 tb/tb_mem_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request, waits a fixed
// latency, then performs a byte-enabled write or a word read against local
// storage and holds the response until the initiator takes it.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    // Operands of the transaction about to complete. With LATENCY=1 the
    // access happens on the acceptance edge itself, before the capture
    // registers hold the request, so the live inputs are used there.
    logic             eff_write_s;
    logic [31:0]      eff_addr_s;
    logic [31:0]      eff_wdata_s;
    logic [3:0]       eff_wstrb_s;
    logic             err_s;
    logic             enter_resp_s;
    logic             mem_we_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      rsp_rdata_d;

    // Select operands, classify the request and decide the RESP transition.
    always_comb begin
        eff_write_s  = wr_q;
        eff_addr_s   = addr_q;
        eff_wdata_s  = wdata_q;
        eff_wstrb_s  = wstrb_q;
        enter_resp_s = 1'b0;
        if (state_q == S_IDLE) begin
            eff_write_s = req_write;
            eff_addr_s  = req_addr;
            eff_wdata_s = req_wdata;
            eff_wstrb_s = req_wstrb;
        end else begin
            eff_write_s = wr_q;
        end
        if (LATENCY == 1) begin
            enter_resp_s = (state_q == S_IDLE) && req_valid;
        end else begin
            enter_resp_s = (state_q == S_WAIT) && (cnt_q == 4'd1);
        end
        err_s    = (eff_addr_s[1:0] != 2'b00) || ({2'b00, eff_addr_s[31:2]} >= DEPTH_W);
        idx_s    = eff_addr_s[IDX_W+1:2];
        mem_we_s = enter_resp_s && eff_write_s && !err_s && !rst;
        if (eff_write_s || err_s) begin
            rsp_rdata_d = 32'h0000_0000;
        end else begin
            rsp_rdata_d = mem_q[idx_s];
        end
    end

    // Storage: byte-enabled write on the edge entering RESP; never reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (eff_wstrb_s[i]) begin
                    mem_q[idx_s][8*i +: 8] <= eff_wdata_s[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with request capture, latency counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            addr_q      <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            wstrb_q     <= 4'b0000;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        wr_q        <= req_write;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        wstrb_q     <= req_wstrb;
                        req_ready_q <= 1'b0;
                        if (enter_resp_s) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rsp_rdata_d;
                            rsp_err_q   <= err_s;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (enter_resp_s) begin
                        state_q     <= S_RESP;
                        cnt_q       <= 4'd0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rsp_rdata_d;
                        rsp_err_q   <= err_s;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'h0000_0000;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= 32'h0000_0000;
                    rsp_err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: table of transactions against a LATENCY=2 instance,
// plus hand sequences for stall, reset-in-WAIT and LATENCY=1 back-to-back.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_wstrb;

    logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [3:0]  b_req_wstrb;

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    typedef struct packed {
        logic        rdata_err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  stall;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [31:0] r, input logic e,
                                input logic [3:0] st);
        vec_t v;
        v.wr = w; v.addr = a; v.wdata = d; v.strb = s;
        v.rdata = r; v.err = e; v.stall = st;
        return v;
    endfunction

    // One transaction on the LATENCY=2 instance, optionally stalling the response.
    task automatic txn(input vec_t v);
        int   lat;
        int   k;
        logic seen;
        exp_t e;
        @(negedge clk);
        rsp_ready = (v.stall == 4'd0);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_wstrb = v.strb;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = ~v.wr;
        req_addr  = ~v.addr;
        req_wdata = ~v.wdata;
        req_wstrb = ~v.strb;
        e.rdata     = v.rdata;
        e.rdata_err = v.err;
        sb.push_back(e);
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat  = c;
                seen = 1'b1;
                break;
            end
            @(posedge clk);
        end
        chk("latency", 32'(lat), 32'd2);
        if (!seen) begin
            void'(sb.pop_front());
            rsp_ready = 1'b1;
            return;
        end
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.rdata_err));
        for (int s = 0; s < int'(v.stall); s++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rdata", rsp_rdata, e.rdata);
            chk("stall_err", 32'(rsp_err), 32'(e.rdata_err));
            chk("stall_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_valid", 32'(rsp_valid), 32'd0);
        chk("post_ready", 32'(req_ready), 32'd1);
        chk("post_rdata", rsp_rdata, 32'h0);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Main stimulus.
    initial begin
        logic exp_ready;
        logic prev_acc;
        exp_t e;

        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_wstrb = 4'h0; rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 32'h0; b_req_wdata = 32'h0;
        b_req_wstrb = 4'h0; b_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst1_req_ready", 32'(b_req_ready), 32'd1);
        chk("rst1_rsp_valid", 32'(b_rsp_valid), 32'd0);

        //             wr    addr          wdata         strb     rdata         err   stall
        tbl.push_back(mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0,         1'b0, 4'd0));
        tbl.push_back(mk(1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0, 4'd0));
        tbl.push_back(mk(1'b1, 32'h0000_0010, 32'h0000_0055, 4'b0001, 32'h0,         1'b0, 4'd0));
        tbl.push_back(mk(1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BE55, 1'b0, 4'd0));
        tbl.push_back(mk(1'b0, 32'h0000_0012, 32'h0,         4'b0000, 32'h0,         1'b1, 4'd0));
        tbl.push_back(mk(1'b0, 32'h0000_0400, 32'h0,         4'b0000, 32'h0,         1'b1, 4'd0));
        tbl.push_back(mk(1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 4'b1111, 32'h0,         1'b1, 4'd0));
        tbl.push_back(mk(1'b1, 32'h0000_0012, 32'hAAAA_AAAA, 4'b1111, 32'h0,         1'b1, 4'd0));
        tbl.push_back(mk(1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BE55, 1'b0, 4'd5));
        tbl.push_back(mk(1'b1, 32'h0000_03FC, 32'h0102_0304, 4'b1111, 32'h0,         1'b0, 4'd0));
        tbl.push_back(mk(1'b1, 32'h0000_03FC, 32'hFFFF_FFFF, 4'b0000, 32'h0,         1'b0, 4'd0));
        tbl.push_back(mk(1'b0, 32'h0000_03FC, 32'h0,         4'b0000, 32'h0102_0304, 1'b0, 4'd0));
        tbl.push_back(mk(1'b1, 32'h0000_0004, 32'h1122_3344, 4'b1111, 32'h0,         1'b0, 4'd0));
        tbl.push_back(mk(1'b1, 32'h0000_0004, 32'h0000_BB00, 4'b0010, 32'h0,         1'b0, 4'd0));
        tbl.push_back(mk(1'b0, 32'h0000_0004, 32'h0,         4'b0000, 32'h1122_BB44, 1'b0, 4'd0));
        tbl.push_back(mk(1'b0, 32'h0000_0401, 32'h0,         4'b0000, 32'h0,         1'b1, 4'd0));
        tbl.push_back(mk(1'b1, 32'h0000_0020, 32'h0000_0000, 4'b1111, 32'h0,         1'b0, 4'd0));
        foreach (tbl[i]) txn(tbl[i]);

        // Reset while the write to 0x20 sits in WAIT: it must not commit.
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0020;
        req_wdata = 32'h1234_5678; req_wstrb = 4'b1111;
        @(posedge clk);
        #1 req_valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("wait_rst_ready", 32'(req_ready), 32'd1);
        chk("wait_rst_valid", 32'(rsp_valid), 32'd0);
        txn(mk(1'b0, 32'h0000_0020, 32'h0, 4'b0000, 32'h0, 1'b0, 4'd0));

        // LATENCY=1 instance: seed a word, then hold req_valid for back-to-back reads.
        @(negedge clk);
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h0000_0008;
        b_req_wdata = 32'hCAFE_F00D; b_req_wstrb = 4'b1111;
        @(posedge clk);
        #1 b_req_valid = 1'b0;
        @(negedge clk);
        chk("l1_wr_valid", 32'(b_rsp_valid), 32'd1);
        chk("l1_wr_err", 32'(b_rsp_err), 32'd0);
        chk("l1_wr_rdata", b_rsp_rdata, 32'h0);
        @(posedge clk);
        #1;
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'h0000_0008;
        exp_ready = 1'b1;
        prev_acc  = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("l1_req_ready", 32'(b_req_ready), 32'(exp_ready));
            chk("l1_rsp_valid", 32'(b_rsp_valid), 32'(prev_acc));
            if (b_rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("l1_sb_empty", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("l1_rdata", b_rsp_rdata, e.rdata);
                    chk("l1_err", 32'(b_rsp_err), 32'(e.rdata_err));
                end
            end
            if (exp_ready) begin
                e.rdata     = 32'hCAFE_F00D;
                e.rdata_err = 1'b0;
                sb.push_back(e);
            end
            prev_acc  = exp_ready;
            exp_ready = ~exp_ready;
        end
        b_req_valid = 1'b0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
